// File: rtl/recognizer_frame_scheduler.sv
// Round-robin scheduler sharing one serial pattern recognizer between two requesters.
// Each frame is cleared into the recognizer, shifted LSB-first, sampled, then reported.
module recognizer_frame_scheduler #(
   parameter int MAX_LEN = 8,
   localparam int LENW = $clog2(MAX_LEN + 1)
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               req0_valid,
   input  logic [MAX_LEN-1:0] req0_data,
   input  logic [LENW-1:0]    req0_len,
   output logic               req0_ready,
   input  logic               req1_valid,
   input  logic [MAX_LEN-1:0] req1_data,
   input  logic [LENW-1:0]    req1_len,
   output logic               req1_ready,
   output logic               rec_clr,
   output logic               rec_en,
   output logic               rec_x,
   input  logic               rec_f,
   output logic               res_valid,
   output logic               res_match,
   output logic               res_src,
   input  logic               res_ready,
   output logic               busy
);

   typedef enum logic [2:0] {
      S_IDLE,
      S_CLEAR,
      S_SHIFT,
      S_SAMPLE,
      S_REPORT
   } state_t;

   state_t             state_q, state_d;
   logic [MAX_LEN-1:0] data_q, data_d;
   logic [LENW-1:0]    len_q, len_d;
   logic [LENW-1:0]    idx_q, idx_d;
   logic               src_q, src_d;
   logic               match_q, match_d;
   logic               last_grant_q, last_grant_d;
   logic               grant0, grant1;
   logic [LENW-1:0]    sel_len;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q      <= S_IDLE;
         data_q       <= '0;
         len_q        <= '0;
         idx_q        <= '0;
         src_q        <= 1'b0;
         match_q      <= 1'b0;
         last_grant_q <= 1'b1;
      end else begin
         state_q      <= state_d;
         data_q       <= data_d;
         len_q        <= len_d;
         idx_q        <= idx_d;
         src_q        <= src_d;
         match_q      <= match_d;
         last_grant_q <= last_grant_d;
      end
   end

   // Grants are gated by rst so no ready pulse can escape while reset is held.
   always_comb begin
      state_d      = state_q;
      data_d       = data_q;
      len_d        = len_q;
      idx_d        = idx_q;
      src_d        = src_q;
      match_d      = match_q;
      last_grant_d = last_grant_q;
      grant0       = 1'b0;
      grant1       = 1'b0;
      sel_len      = '0;
      rec_clr      = 1'b0;
      rec_en       = 1'b0;
      rec_x        = 1'b0;
      res_valid    = 1'b0;

      case (state_q)
         S_IDLE: begin
            if (rst) begin
               grant0 = req0_valid & (~req1_valid | last_grant_q);
               grant1 = req1_valid & (~req0_valid | ~last_grant_q);
            end
            if (grant0 | grant1) begin
               sel_len = grant1 ? req1_len : req0_len;
               data_d  = grant1 ? req1_data : req0_data;
               len_d   = (sel_len > LENW'(MAX_LEN)) ? LENW'(MAX_LEN) : sel_len;
               src_d   = grant1;
               match_d = 1'b0;
               idx_d   = '0;
               state_d = (sel_len == '0) ? S_REPORT : S_CLEAR;
            end
         end
         S_CLEAR: begin
            rec_clr = 1'b1;
            state_d = S_SHIFT;
         end
         S_SHIFT: begin
            // The frame register shifts right so bit 0 is always the next bit out.
            rec_en = 1'b1;
            rec_x  = data_q[0];
            data_d = data_q >> 1;
            idx_d  = idx_q + LENW'(1);
            if (idx_q == len_q - LENW'(1)) begin
               state_d = S_SAMPLE;
            end
         end
         S_SAMPLE: begin
            match_d = rec_f;
            state_d = S_REPORT;
         end
         S_REPORT: begin
            res_valid = 1'b1;
            if (res_ready) begin
               last_grant_d = src_q;
               state_d      = S_IDLE;
            end
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   assign req0_ready = grant0;
   assign req1_ready = grant1;
   assign res_match  = match_q;
   assign res_src    = src_q;
   assign busy       = (state_q != S_IDLE);

endmodule

// File: tb/tb_recognizer_frame_scheduler.sv
// Self-checking bench for recognizer_frame_scheduler: a frame-level timing model plus
// directed scenarios with hand-computed expectations, followed by randomized traffic.
module tb_recognizer_frame_scheduler;

   localparam int MAX_LEN = 8;
   localparam int LENW    = 4;

   logic            clk;
   logic            rst;
   logic            req0Valid, req1Valid;
   logic [7:0]      req0Data, req1Data;
   logic [LENW-1:0] req0Len, req1Len;
   logic            req0Ready, req1Ready;
   logic            recClr, recEn, recX, recF;
   logic            resValid, resMatch, resSrc, resReady;
   logic            busy;

   int vecCount  = 0;
   int missCount = 0;

   recognizer_frame_scheduler #(.MAX_LEN(MAX_LEN)) dut (
      .clk(clk), .rst(rst),
      .req0_valid(req0Valid), .req0_data(req0Data), .req0_len(req0Len), .req0_ready(req0Ready),
      .req1_valid(req1Valid), .req1_data(req1Data), .req1_len(req1Len), .req1_ready(req1Ready),
      .rec_clr(recClr), .rec_en(recEn), .rec_x(recX), .rec_f(recF),
      .res_valid(resValid), .res_match(resMatch), .res_src(resSrc), .res_ready(resReady),
      .busy(busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Recognizer stand-in: counts 1s (saturating at two) and tracks parity of 0s.
   // It is deliberately not reset by rst, so only CLEAR can wipe stale state.
   logic [1:0] recOnes = 2'd0;
   logic       recZpar = 1'b0;
   always @(posedge clk) begin
      if (recClr) begin
         recOnes <= 2'd0;
         recZpar <= 1'b0;
      end else if (recEn) begin
         if (recX) recOnes <= (recOnes == 2'd2) ? 2'd2 : recOnes + 2'd1;
         else      recZpar <= ~recZpar;
      end
   end
   assign recF = (recOnes == 2'd2) && recZpar;

   task automatic checkOutput(input string name, input int actual, input int expected);
      vecCount++;
      if (actual != expected) begin
         missCount++;
         $display("[TB] FAIL %s: got %0d, expected %0d at %0t", name, actual, expected, $time);
      end
   endtask

   function automatic int patternMatch(input logic [7:0] data, input int len);
      int ones = 0;
      int zeros = 0;
      for (int i = 0; i < len; i++) begin
         if (data[i]) ones++;
         else zeros++;
      end
      return ((ones >= 2) && (zeros % 2 == 1)) ? 1 : 0;
   endfunction

   // Frame-level reference: a frame accepted at k=0 clears at k=1, shifts at
   // k=2..L+1, samples at k=L+2 and reports from k=L+3 (from k=1 when L=0).
   int         mBusy = 0;
   int         mK    = 0;
   int         mLen  = 0;
   logic [7:0] mData = 8'h00;
   int         mSrc  = 0;
   int         mLast = 1;

   always @(negedge clk) begin
      int eR0, eR1, eClr, eEn, eX, eValid, eBusy, reportAt, g;
      eR0 = 0; eR1 = 0; eClr = 0; eEn = 0; eX = 0; eValid = 0; eBusy = 0; g = -1;
      reportAt = (mLen == 0) ? 1 : mLen + 3;
      if (rst && mBusy == 0) begin
         if (req0Valid && req1Valid) g = (mLast == 1) ? 0 : 1;
         else if (req0Valid)         g = 0;
         else if (req1Valid)         g = 1;
         eR0 = (g == 0) ? 1 : 0;
         eR1 = (g == 1) ? 1 : 0;
      end else if (rst) begin
         eBusy = 1;
         if (mK >= reportAt) eValid = 1;
         else if (mK == 1) eClr = 1;
         else if (mK >= 2 && mK <= mLen + 1) begin
            eEn = 1;
            eX  = int'(mData[mK-2]);
         end
      end
      checkOutput("req0_ready", int'(req0Ready), eR0);
      checkOutput("req1_ready", int'(req1Ready), eR1);
      checkOutput("rec_clr",    int'(recClr),    eClr);
      checkOutput("rec_en",     int'(recEn),     eEn);
      checkOutput("rec_x",      int'(recX),      eX);
      checkOutput("res_valid",  int'(resValid),  eValid);
      checkOutput("busy",       int'(busy),      eBusy);
      if (!rst) begin
         checkOutput("res_match_rst", int'(resMatch), 0);
         checkOutput("res_src_rst",   int'(resSrc),   0);
      end else if (eValid == 1) begin
         checkOutput("res_match", int'(resMatch), patternMatch(mData, mLen));
         checkOutput("res_src",   int'(resSrc),   mSrc);
      end

      if (!rst) begin
         mBusy = 0; mK = 0; mLast = 1; mLen = 0;
      end else if (mBusy == 0) begin
         if (g >= 0) begin
            mBusy = 1;
            mK    = 1;
            mSrc  = g;
            mData = (g == 1) ? req1Data : req0Data;
            mLen  = (g == 1) ? int'(req1Len) : int'(req0Len);
            if (mLen > MAX_LEN) mLen = MAX_LEN;
         end
      end else if (mK >= reportAt && resReady) begin
         mBusy = 0;
         mLast = mSrc;
      end else begin
         mK++;
      end
   end

   task automatic applyStimulus(input logic v0, input logic [7:0] d0, input logic [3:0] l0,
                                input logic v1, input logic [7:0] d1, input logic [3:0] l1,
                                input logic rr);
      @(posedge clk);
      #1;
      req0Valid = v0; req0Data = d0; req0Len = l0;
      req1Valid = v1; req1Data = d1; req1Len = l1;
      resReady  = rr;
   endtask

   task automatic waitIdle();
      bit seen = 0;
      applyStimulus(0, 8'h00, 4'd0, 0, 8'h00, 4'd0, 1);
      for (int n = 0; n < 60; n++) begin
         @(negedge clk);
         if (!busy) begin
            seen = 1;
            break;
         end
      end
      if (!seen) checkOutput("idle_timeout", 0, 1);
   endtask

   task automatic runFrame(input logic src, input logic [7:0] data, input logic [3:0] len,
                           input int expMatch, input int expLat, input int expEn, input int expClr);
      int enCnt = 0;
      int clrCnt = 0;
      int lat = 0;
      waitIdle();
      applyStimulus(~src, data, len, src, data, len, 1);
      @(negedge clk);
      checkOutput("accept_ready", src ? int'(req1Ready) : int'(req0Ready), 1);
      applyStimulus(0, 8'h00, 4'd0, 0, 8'h00, 4'd0, 1);
      for (int n = 1; n <= 40; n++) begin
         if (n > 1) @(negedge clk);
         else @(negedge clk);
         if (recEn)  enCnt++;
         if (recClr) clrCnt++;
         if (resValid) begin
            lat = n;
            break;
         end
      end
      checkOutput("frame_latency",  lat,    expLat);
      checkOutput("frame_en_count", enCnt,  expEn);
      checkOutput("frame_clr_count", clrCnt, expClr);
      checkOutput("frame_match",    int'(resMatch), expMatch);
      checkOutput("frame_src",      int'(resSrc),   int'(src));
   endtask

   initial begin
      int grants[4];
      int nGrants;
      int pulses;
      bit seen;

      rst = 1'b0;
      req0Valid = 0; req0Data = 0; req0Len = 0;
      req1Valid = 0; req1Data = 0; req1Len = 0;
      resReady = 0;

      checkOutput("pin_011_len3",  patternMatch(8'b011, 3), 1);
      checkOutput("pin_1001_len4", patternMatch(8'b1001, 4), 0);
      checkOutput("pin_01_len2",   patternMatch(8'b01, 2), 0);
      checkOutput("pin_FE_len8",   patternMatch(8'hFE, 8), 1);

      repeat (3) @(posedge clk);
      @(negedge clk);
      checkOutput("reset_busy",      int'(busy), 0);
      checkOutput("reset_res_valid", int'(resValid), 0);
      @(posedge clk);
      #1 rst = 1'b1;

      // Basic match, non-matches for even zeros and a single 1.
      runFrame(0, 8'b011, 4'd3, 1, 6, 3, 1);
      runFrame(1, 8'b1001, 4'd4, 0, 7, 4, 1);
      runFrame(1, 8'b01, 4'd2, 0, 5, 2, 1);

      // Continuous contention alternates grants.
      waitIdle();
      applyStimulus(1, 8'h01, 4'd1, 1, 8'h03, 4'd1, 1);
      nGrants = 0;
      for (int n = 0; n < 80 && nGrants < 4; n++) begin
         @(negedge clk);
         if (req0Ready) begin grants[nGrants] = 0; nGrants++; end
         else if (req1Ready) begin grants[nGrants] = 1; nGrants++; end
      end
      checkOutput("rr_grant_count", nGrants, 4);
      for (int i = 0; i < nGrants; i++) checkOutput("rr_grant_order", grants[i], i % 2);

      // Backpressure holds the result and blocks new grants.
      waitIdle();
      applyStimulus(1, 8'b011, 4'd3, 0, 8'h00, 4'd0, 0);
      @(negedge clk);
      checkOutput("bp_accept", int'(req0Ready), 1);
      applyStimulus(0, 8'h00, 4'd0, 1, 8'hFF, 4'd4, 0);
      seen = 0;
      for (int n = 0; n < 20; n++) begin
         @(negedge clk);
         if (resValid) begin seen = 1; break; end
      end
      checkOutput("bp_result_seen", int'(seen), 1);
      pulses = 0;
      for (int n = 0; n < 10; n++) begin
         @(negedge clk);
         if (req0Ready || req1Ready) pulses++;
         checkOutput("bp_hold_valid", int'(resValid), 1);
         checkOutput("bp_hold_match", int'(resMatch), 1);
      end
      checkOutput("bp_no_grant", pulses, 0);
      applyStimulus(0, 8'h00, 4'd0, 0, 8'h00, 4'd0, 1);
      @(negedge clk);
      checkOutput("bp_handshake", int'(resValid), 1);
      @(negedge clk);
      checkOutput("bp_single_result", int'(resValid), 0);

      // Zero length and over-long frames.
      runFrame(0, 8'h00, 4'd0, 0, 1, 0, 0);
      runFrame(0, 8'hFE, 4'd11, 1, 11, 8, 1);

      // Reset during the third shifted bit, then a frame that stale state would corrupt.
      waitIdle();
      applyStimulus(1, 8'b00011, 4'd5, 0, 8'h00, 4'd0, 1);
      @(negedge clk);
      checkOutput("rst_accept", int'(req0Ready), 1);
      applyStimulus(0, 8'h00, 4'd0, 0, 8'h00, 4'd0, 1);
      repeat (3) @(posedge clk);
      #2;
      checkOutput("rst_pre_shift", int'(recEn), 1);
      #1 rst = 1'b0;
      #1;
      checkOutput("rst_async_en",    int'(recEn), 0);
      checkOutput("rst_async_x",     int'(recX), 0);
      checkOutput("rst_async_busy",  int'(busy), 0);
      checkOutput("rst_async_valid", int'(resValid), 0);
      repeat (2) @(posedge clk);
      #1 rst = 1'b1;
      runFrame(1, 8'h00, 4'd1, 0, 4, 1, 1);

      // Randomized traffic against the reference model.
      for (int n = 0; n < 800; n++) begin
         applyStimulus($urandom_range(0, 1) == 1, 8'($urandom), 4'($urandom_range(0, 11)),
                       $urandom_range(0, 1) == 1, 8'($urandom), 4'($urandom_range(0, 11)),
                       $urandom_range(0, 9) < 7);
      end
      waitIdle();

      $display("== %0d vectors applied, %0d miscompares ==", vecCount, missCount);
      $finish;
   end

endmodule
